// File: rtl/sysmgr_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sysmgr_pkg
//  Purpose : Shared definitions for the clock-domain sequencer: FSM state
//            encoding and a ceiling-log2 helper for counter widths.
//  Rev     : 1.0  initial release
// ============================================================================
package sysmgr_pkg;

   // Sequencer FSM state encoding
   typedef logic [1:0] state_t;

   localparam state_t ST_WAIT_LOCK = 2'd0;
   localparam state_t ST_RELEASE   = 2'd1;
   localparam state_t ST_RUN       = 2'd2;

   // Ceiling log2 with a floor of 1 so that degenerate parameter values
   // (a ratio, length or count of 1) still yield a legal 1-bit counter.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage : sysmgr_pkg
`default_nettype wire

// File: rtl/sysmgr_lock_filt.sv
`default_nettype none
// ============================================================================
//  Module  : sysmgr_lock_filt
//  Purpose : Two-flop synchroniser for the raw PLL lock followed by a
//            saturating run-length filter. lock_ok is a registered flag that
//            says the synchronised lock has been high for LOCK_FILT
//            consecutive cycles.
//  Rev     : 1.0  initial release
// ============================================================================
module sysmgr_lock_filt
   import sysmgr_pkg::*;
#(
   parameter int LOCK_FILT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pll_lock,
   input  logic clear,
   output logic lock_s,
   output logic lock_ok
);

   localparam int               FW       = clog2(LOCK_FILT);
   localparam logic [FW-1:0]    FILT_MAX = FW'(LOCK_FILT - 1);

   logic          sync_meta;
   logic [FW-1:0] filt;
   logic          filt_full;

   // Filter has seen the full run of consecutive lock-high cycles
   always_comb begin
      filt_full = lock_s && (filt == FILT_MAX);
   end

   // Metastability synchroniser: pll_lock is asynchronous to clk
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         sync_meta <= pll_lock;
         lock_s    <= sync_meta;
      end
   end

   // Saturating run-length counter; any low cycle or a clear restarts it.
   // lock_ok is registered so the sequencer never sees a combinational path
   // from the counter compare.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filt    <= '0;
         lock_ok <= 1'b0;
      end else begin
         if (clear || !lock_s) begin
            filt <= '0;
         end else if (filt != FILT_MAX) begin
            filt <= filt + FW'(1);
         end
         lock_ok <= !clear && filt_full;
      end
   end

endmodule : sysmgr_lock_filt
`default_nettype wire

// File: rtl/sysmgr_seq.sv
`default_nettype none
// ============================================================================
//  Module  : sysmgr_seq
//  Purpose : Fast-clock sequencer. Generates a programmable-ratio,
//            programmable-phase slow-domain sync strobe, filters the PLL lock
//            and releases N_CH staged channel resets, each on a slow-clock
//            boundary. Lock loss or a soft reset re-runs the whole sequence.
//  Rev     : 1.0  initial release
// ============================================================================
module sysmgr_seq
   import sysmgr_pkg::*;
#(
   parameter int RATIO     = 4,
   parameter int PHASE     = 2,
   parameter int N_CH      = 3,
   parameter int STAGE_LEN = 16,
   parameter int LOCK_FILT = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pll_lock,
   input  logic                    soft_rst,
   output logic [clog2(RATIO)-1:0] phase,
   output logic                    sync,
   output logic [N_CH-1:0]         rst,
   output logic                    ready
);

   localparam int            PW       = clog2(RATIO);
   localparam int            SW       = clog2(STAGE_LEN);
   localparam int            CW       = clog2(N_CH);
   localparam logic [PW-1:0] PH_LAST  = PW'(RATIO - 1);
   localparam logic [PW-1:0] PH_SYNC  = PW'(PHASE);
   localparam logic [SW-1:0] STG_LAST = SW'(STAGE_LEN - 1);
   localparam logic [CW-1:0] CH_LAST  = CW'(N_CH - 1);

   logic            lock_s;
   logic            lock_ok;

   logic [PW-1:0]   phase_nxt;

   state_t          state;
   state_t          state_nxt;
   logic [SW-1:0]   stg;
   logic [SW-1:0]   stg_nxt;
   logic [CW-1:0]   ch;
   logic [CW-1:0]   ch_nxt;
   logic [N_CH-1:0] rst_nxt;
   logic            ready_nxt;

   logic            abort;
   logic            release_due;
   logic            last_ch;

   // ------------------------------------------------------------------------
   // Lock synchroniser and filter; soft reset restarts the filter run.
   // ------------------------------------------------------------------------
   sysmgr_lock_filt #(
      .LOCK_FILT (LOCK_FILT)
   ) u_lock_filt (
      .clk      (clk),
      .rst_n    (rst_n),
      .pll_lock (pll_lock),
      .clear    (soft_rst),
      .lock_s   (lock_s),
      .lock_ok  (lock_ok)
   );

   // ------------------------------------------------------------------------
   // Phase counter. Only rst_n clears it, so the slow-domain alignment
   // survives lock loss and soft reset.
   // ------------------------------------------------------------------------

   // Free-running 0..RATIO-1 wrap
   always_comb begin
      phase_nxt = (phase == PH_LAST) ? '0 : phase + PW'(1);
   end

   // Phase register and registered sync strobe aligned with phase == PHASE
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase <= '0;
         sync  <= 1'b0;
      end else begin
         phase <= phase_nxt;
         sync  <= (phase_nxt == PH_SYNC);
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------------

   // Shared decode: abort conditions and the release slot. Releasing on the
   // last phase makes the registered edge appear on the first cycle of
   // phase 0, i.e. on a slow-clock boundary.
   always_comb begin
      abort       = !lock_s || soft_rst;
      release_due = (stg == STG_LAST) && (phase == PH_LAST);
      last_ch     = (ch == CH_LAST);
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_WAIT_LOCK;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort wins over any release or transition
   always_comb begin
      state_nxt = state;
      case (state)
         ST_WAIT_LOCK: begin
            if (!soft_rst && lock_s && lock_ok) begin
               state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (abort) begin
               state_nxt = ST_WAIT_LOCK;
            end else if (release_due && last_ch) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_nxt = ST_WAIT_LOCK;
            end
         end
         default: begin
            state_nxt = ST_WAIT_LOCK;
         end
      endcase
   end

   // Output logic: next values of the channel resets, ready and stage counters
   always_comb begin
      rst_nxt   = rst;
      ready_nxt = ready;
      ch_nxt    = ch;
      stg_nxt   = stg;
      case (state)
         ST_WAIT_LOCK: begin
            rst_nxt   = '1;
            ready_nxt = 1'b0;
            ch_nxt    = '0;
            stg_nxt   = '0;
         end
         ST_RELEASE: begin
            ready_nxt = 1'b0;
            if (abort) begin
               rst_nxt = '1;
               ch_nxt  = '0;
               stg_nxt = '0;
            end else if (release_due) begin
               stg_nxt = '0;
               if (last_ch) begin
                  rst_nxt   = '0;
                  ready_nxt = 1'b1;
                  ch_nxt    = '0;
               end else begin
                  // bit 0 releases first; a zero shifts in from the bottom
                  rst_nxt = rst << 1;
                  ch_nxt  = ch + CW'(1);
               end
            end else if (stg != STG_LAST) begin
               stg_nxt = stg + SW'(1);
            end
         end
         ST_RUN: begin
            ch_nxt  = '0;
            stg_nxt = '0;
            if (abort) begin
               rst_nxt   = '1;
               ready_nxt = 1'b0;
            end else begin
               rst_nxt   = '0;
               ready_nxt = 1'b1;
            end
         end
         default: begin
            rst_nxt   = '1;
            ready_nxt = 1'b0;
            ch_nxt    = '0;
            stg_nxt   = '0;
         end
      endcase
   end

   // Registered channel resets, ready flag and stage/channel counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rst   <= '1;
         ready <= 1'b0;
         ch    <= '0;
         stg   <= '0;
      end else begin
         rst   <= rst_nxt;
         ready <= ready_nxt;
         ch    <= ch_nxt;
         stg   <= stg_nxt;
      end
   end

endmodule : sysmgr_seq
`default_nettype wire

// File: tb/tb_sysmgr_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sysmgr_seq
//  Purpose : Directed bench for sysmgr_seq. One default-parameter instance
//            driven from a checkpoint table, plus RATIO 2 and RATIO 16
//            single-channel instances. Cycle k is the k-th rising edge after
//            rst_n is released; inputs set during cycle k are sampled by edge
//            k+1; outputs are sampled on the falling edge.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_sysmgr_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_lock;
   logic       soft_rst;
   logic       lock_p;
   logic       zero;

   logic [1:0] phase;
   logic       sync;
   logic [2:0] rst;
   logic       ready;

   logic [0:0] phase_a;
   logic       sync_a;
   logic [0:0] rst_a;
   logic       ready_a;

   logic [3:0] phase_b;
   logic       sync_b;
   logic [0:0] rst_b;
   logic       ready_b;

   int         cyc;
   bit         track;
   int         n_tests;
   int         n_fail;

   always #5 clk = ~clk;

   sysmgr_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .pll_lock (pll_lock),
      .soft_rst (soft_rst),
      .phase    (phase),
      .sync     (sync),
      .rst      (rst),
      .ready    (ready)
   );

   sysmgr_seq #(
      .RATIO (2), .PHASE (1), .N_CH (1), .STAGE_LEN (16), .LOCK_FILT (8)
   ) dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .pll_lock (lock_p),
      .soft_rst (zero),
      .phase    (phase_a),
      .sync     (sync_a),
      .rst      (rst_a),
      .ready    (ready_a)
   );

   sysmgr_seq #(
      .RATIO (16), .PHASE (15), .N_CH (1), .STAGE_LEN (16), .LOCK_FILT (8)
   ) dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .pll_lock (lock_p),
      .soft_rst (zero),
      .phase    (phase_b),
      .sync     (sync_b),
      .rst      (rst_b),
      .ready    (ready_b)
   );

   // checkpoint record: at cycle cyc compare instance sel (0 main, 1 RATIO 2,
   // 2 RATIO 16); if upd, then drive the main instance's inputs
   typedef struct {
      int         cyc;
      int         sel;
      logic [2:0] rst_e;
      logic       rdy_e;
      bit         upd;
      logic       lock;
      logic       srst;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int c, input int s, input logic [2:0] r,
                               input logic rd, input bit u, input logic l,
                               input logic sr);
      vec_t v;
      v.cyc   = c;
      v.sel   = s;
      v.rst_e = r;
      v.rdy_e = rd;
      v.upd   = u;
      v.lock  = l;
      v.srst  = sr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h",
                  name, cyc, act, exp);
      end
   endtask

   // free-running phase/sync reference for all three instances
   task automatic check_phase();
      check("phase",   32'(phase),   32'(cyc % 4));
      check("sync",    32'(sync),    32'((cyc % 4) == 2));
      check("phase_a", 32'(phase_a), 32'(cyc % 2));
      check("sync_a",  32'(sync_a),  32'((cyc % 2) == 1));
      check("phase_b", 32'(phase_b), 32'(cyc % 16));
      check("sync_b",  32'(sync_b),  32'((cyc % 16) == 15));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_phase"},   32'(phase),   32'd0);
      check({tag, "_sync"},    32'(sync),    32'd0);
      check({tag, "_rst"},     32'(rst),     32'h7);
      check({tag, "_ready"},   32'(ready),   32'd0);
      check({tag, "_phase_a"}, 32'(phase_a), 32'd0);
      check({tag, "_rst_a"},   32'(rst_a),   32'd1);
      check({tag, "_ready_a"}, 32'(ready_a), 32'd0);
      check({tag, "_phase_b"}, 32'(phase_b), 32'd0);
      check({tag, "_rst_b"},   32'(rst_b),   32'd1);
      check({tag, "_ready_b"}, 32'(ready_b), 32'd0);
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (track) begin
         check_phase();
      end
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      cyc      = 0;
      track    = 1'b0;
      rst_n    = 1'b0;
      pll_lock = 1'b0;
      soft_rst = 1'b0;
      lock_p   = 1'b0;
      zero     = 1'b0;

      // main instance: sync cadence, clean bring-up, lock loss, soft reset
      // mid-release, lock glitch
      vecs.push_back(mk(  0, 0, 3'b111, 1'b0, 1, 1'b0, 1'b0));
      vecs.push_back(mk(  2, 0, 3'b111, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk(  5, 0, 3'b111, 1'b0, 1, 1'b1, 1'b0));
      vecs.push_back(mk( 15, 0, 3'b111, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk( 27, 1, 3'b001, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk( 28, 1, 3'b000, 1'b1, 0, 1'b0, 1'b0));
      vecs.push_back(mk( 31, 0, 3'b111, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk( 31, 2, 3'b001, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk( 32, 0, 3'b110, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk( 32, 2, 3'b000, 1'b1, 0, 1'b0, 1'b0));
      vecs.push_back(mk( 47, 0, 3'b110, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk( 48, 0, 3'b100, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk( 63, 0, 3'b100, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk( 64, 0, 3'b000, 1'b1, 0, 1'b0, 1'b0));
      vecs.push_back(mk( 80, 0, 3'b000, 1'b1, 1, 1'b0, 1'b0));
      vecs.push_back(mk( 82, 0, 3'b000, 1'b1, 0, 1'b0, 1'b0));
      vecs.push_back(mk( 83, 0, 3'b111, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk( 90, 0, 3'b111, 1'b0, 1, 1'b1, 1'b0));
      vecs.push_back(mk(119, 0, 3'b111, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk(120, 0, 3'b110, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk(136, 0, 3'b100, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk(151, 0, 3'b100, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk(152, 0, 3'b000, 1'b1, 0, 1'b0, 1'b0));
      vecs.push_back(mk(160, 0, 3'b000, 1'b1, 1, 1'b1, 1'b1));
      vecs.push_back(mk(161, 0, 3'b111, 1'b0, 1, 1'b1, 1'b0));
      vecs.push_back(mk(187, 0, 3'b111, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk(188, 0, 3'b110, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk(203, 0, 3'b110, 1'b0, 1, 1'b1, 1'b1));
      vecs.push_back(mk(204, 0, 3'b111, 1'b0, 1, 1'b1, 1'b0));
      vecs.push_back(mk(205, 0, 3'b111, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk(208, 0, 3'b111, 1'b0, 1, 1'b0, 1'b0));
      vecs.push_back(mk(209, 0, 3'b111, 1'b0, 1, 1'b1, 1'b0));
      vecs.push_back(mk(232, 0, 3'b111, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk(235, 0, 3'b111, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk(236, 0, 3'b110, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk(252, 0, 3'b100, 1'b0, 0, 1'b0, 1'b0));
      vecs.push_back(mk(268, 0, 3'b000, 1'b1, 0, 1'b0, 1'b0));

      // reset values while rst_n is held low
      repeat (3) @(negedge clk);
      check_reset_values("por");

      // release rst_n; this falling edge is inside cycle 0
      rst_n  = 1'b1;
      lock_p = 1'b1;
      track  = 1'b1;
      check_phase();

      foreach (vecs[i]) begin
         while (cyc < vecs[i].cyc) begin
            step();
         end
         case (vecs[i].sel)
            1: begin
               check($sformatf("v%0d_rst_a", i),   32'(rst_a),   32'(vecs[i].rst_e));
               check($sformatf("v%0d_ready_a", i), 32'(ready_a), 32'(vecs[i].rdy_e));
            end
            2: begin
               check($sformatf("v%0d_rst_b", i),   32'(rst_b),   32'(vecs[i].rst_e));
               check($sformatf("v%0d_ready_b", i), 32'(ready_b), 32'(vecs[i].rdy_e));
            end
            default: begin
               check($sformatf("v%0d_rst", i),   32'(rst),   32'(vecs[i].rst_e));
               check($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].rdy_e));
            end
         endcase
         if (vecs[i].upd) begin
            pll_lock = vecs[i].lock;
            soft_rst = vecs[i].srst;
         end
      end

      // rst_n asserted mid-run: everything returns to reset values even with
      // lock held, then the phase counter restarts from 0
      track = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_values("mid");
      rst_n = 1'b1;
      cyc   = 0;
      track = 1'b1;
      check_phase();
      for (int k = 0; k < 6; k++) begin
         step();
      end
      check("restart_rst",   32'(rst),   32'h7);
      check("restart_ready", 32'(ready), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_sysmgr_seq
`default_nettype wire
